// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot front end.
//
// Purpose:
//   Fixed-point constants for the Q10.22 coordinate format, default raster
//   dimensions and the state encoding of the raster scan generator.
//
// Contents:
//   FRAC_BITS      fractional bits of a Q10.22 coordinate
//   Q_ONE          1.0 in Q10.22
//   ESCAPE_SQ      |z|^2 escape threshold (4.0) in Q10.22
//   DEFAULT_H_RES  default pixels per line
//   DEFAULT_V_RES  default lines per frame
//   scan_state_t   IDLE / SCAN / DRAIN
package mandelbrot_pkg;

    localparam int          FRAC_BITS     = 22;
    localparam logic [31:0] Q_ONE         = 32'h0040_0000;
    localparam logic [31:0] ESCAPE_SQ     = 32'h0100_0000;

    localparam int          DEFAULT_H_RES = 640;
    localparam int          DEFAULT_V_RES = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mandelbrot_scan_gen_if.sv
// Bus between the raster scan generator and the host / iteration pipeline.
//
// Purpose:
//   Groups the frame control inputs, the per-pixel c stream and the aligned
//   result tags into a single bundle.
//
// Signals (direction seen from the scan generator, modport master):
//   start       in   begin a frame (only honoured while idle)
//   en          in   issue enable, 0 inserts a bubble
//   re_origin   in   real part of pixel (0,0)
//   im_origin   in   imag part of pixel (0,0)
//   step        in   pixel pitch for both axes
//   c_real_out  out  real part of c to the pipeline
//   c_imag_out  out  imag part of c to the pipeline
//   c_valid     out  c_*_out carries a real pixel this cycle
//   res_valid   out  pipeline output this cycle belongs to (res_x,res_y)
//   res_x       out  aligned x tag
//   res_y       out  aligned y tag
//   busy        out  frame in progress
//   done        out  one-cycle pulse with the final result beat
interface mandelbrot_scan_gen_if #(
    parameter int WIDTH = 32,
    parameter int XW    = 10,
    parameter int YW    = 9
);

    logic             start;
    logic             en;
    logic [WIDTH-1:0] re_origin;
    logic [WIDTH-1:0] im_origin;
    logic [WIDTH-1:0] step;

    logic [WIDTH-1:0] c_real_out;
    logic [WIDTH-1:0] c_imag_out;
    logic             c_valid;
    logic             res_valid;
    logic [XW-1:0]    res_x;
    logic [YW-1:0]    res_y;
    logic             busy;
    logic             done;

    modport master (
        input  start, en, re_origin, im_origin, step,
        output c_real_out, c_imag_out, c_valid,
        output res_valid, res_x, res_y, busy, done
    );

    modport slave (
        output start, en, re_origin, im_origin, step,
        input  c_real_out, c_imag_out, c_valid,
        input  res_valid, res_x, res_y, busy, done
    );

endinterface

// File: rtl/mandelbrot_tag_delay.sv
// Fixed-latency tag delay line.
//
// Purpose:
//   Shifts a valid bit plus a DW-bit payload through DEPTH register stages,
//   advancing every clock with no stall, so the tail lines up with the
//   output of a pipeline of the same latency.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears every stage
//   in_valid   in   valid bit entering stage 0
//   in_data    in   payload entering stage 0
//   out_valid  out  valid bit at the tail (stage DEPTH-1)
//   out_data   out  payload at the tail
module mandelbrot_tag_delay
    import mandelbrot_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_sr [DEPTH];
    logic [DW-1:0] data_sr  [DEPTH];

    // Payload is cleared together with the valid bits so the tag outputs
    // read as zero straight out of reset, not just the valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_sr[i] <= 1'b0;
                data_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/mandelbrot_scan_gen.sv
// Raster scan generator for the Mandelbrot iteration pipeline.
//
// Purpose:
//   Issues one complex point c per enabled cycle, walking the frame in
//   raster order from a latched origin with a latched pitch (real grows to
//   the right, imaginary falls down the screen). Each issued pixel's (x,y)
//   tag travels through a delay line matched to the pipeline latency so the
//   escape result leaving the pipeline can be paired with its pixel.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low
//   bus    master modport of mandelbrot_scan_gen_if (control in, c stream
//          and aligned result tags out)
module mandelbrot_scan_gen
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int H_RES        = DEFAULT_H_RES,
    parameter int V_RES        = DEFAULT_V_RES,
    parameter int XW           = 10,
    parameter int YW           = 9,
    parameter int PIPE_LATENCY = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    mandelbrot_scan_gen_if.master bus
);

    localparam int TAG_W = 1 + XW + YW;

    scan_state_t      state;
    scan_state_t      state_next;
    logic             load;
    logic             issue;

    logic [WIDTH-1:0] lat_re;
    logic [WIDTH-1:0] lat_step;
    logic [WIDTH-1:0] c_real;
    logic [WIDTH-1:0] c_imag;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;

    logic [WIDTH-1:0] c_real_q;
    logic [WIDTH-1:0] c_imag_q;
    logic             c_valid_q;
    logic [XW-1:0]    tag_x;
    logic [YW-1:0]    tag_y;
    logic             tag_last;

    logic             at_eol;
    logic             at_last;

    logic             tail_valid;
    logic [TAG_W-1:0] tail_data;
    logic             tail_last;

    // With H_RES or V_RES of 1 these compares are constantly true, which
    // makes every pixel a line wrap and lets the last-pixel test coincide.
    assign at_eol  = (x == XW'(H_RES - 1));
    assign at_last = at_eol && (y == YW'(V_RES - 1));

    assign tail_last = tail_data[TAG_W-1];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only honoured while idle; the final issue
    // moves to DRAIN, and DRAIN ends on the cycle the last-tagged beat sits
    // at the tail of the delay line.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.en) begin
                    issue = 1'b1;
                    if (at_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tail_valid && tail_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Scan counters and coordinate accumulators. The real part is reloaded
    // from the latched origin at each line wrap instead of being stepped
    // back, so rounding never accumulates across lines. Nothing advances
    // after the last pixel so the outputs keep showing it during DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_re   <= '0;
            lat_step <= '0;
            c_real   <= '0;
            c_imag   <= '0;
            x        <= '0;
            y        <= '0;
        end else if (load) begin
            lat_re   <= bus.re_origin;
            lat_step <= bus.step;
            c_real   <= bus.re_origin;
            c_imag   <= bus.im_origin;
            x        <= '0;
            y        <= '0;
        end else if (issue && !at_last) begin
            if (at_eol) begin
                x      <= '0;
                y      <= y + YW'(1);
                c_real <= lat_re;
                c_imag <= c_imag - lat_step;
            end else begin
                x      <= x + XW'(1);
                c_real <= c_real + lat_step;
            end
        end
    end

    // Registered c stream and the tag of the pixel being shown. During
    // bubbles and DRAIN the previous values are held and only c_valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_real_q  <= '0;
            c_imag_q  <= '0;
            c_valid_q <= 1'b0;
            tag_x     <= '0;
            tag_y     <= '0;
            tag_last  <= 1'b0;
        end else begin
            c_valid_q <= issue;
            if (issue) begin
                c_real_q <= c_real;
                c_imag_q <= c_imag;
                tag_x    <= x;
                tag_y    <= y;
                tag_last <= at_last;
            end
        end
    end

    // The delay line samples the cycle in which c_valid is high, so the
    // tag surfaces exactly PIPE_LATENCY cycles after its c beat.
    mandelbrot_tag_delay #(
        .DEPTH (PIPE_LATENCY),
        .DW    (TAG_W)
    ) u_tag_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (c_valid_q),
        .in_data   ({tag_last, tag_x, tag_y}),
        .out_valid (tail_valid),
        .out_data  (tail_data)
    );

    assign bus.c_real_out = c_real_q;
    assign bus.c_imag_out = c_imag_q;
    assign bus.c_valid    = c_valid_q;
    assign bus.res_valid  = tail_valid;
    assign bus.res_x      = tail_data[XW+YW-1:YW];
    assign bus.res_y      = tail_data[YW-1:0];
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = tail_valid && tail_last;

endmodule

// File: tb/tb_mandelbrot_scan_gen.sv
// Testbench for mandelbrot_scan_gen.
//
// Purpose:
//   Drives two instances: a 4x3 frame with a 14-cycle pipeline, and a 1x1
//   frame with a 1-cycle pipeline. Expected pixels come from raster-order
//   arithmetic (origin + x*step, origin - y*step) and a scoreboard of
//   issued tags with their issue cycle.
module tb_mandelbrot_scan_gen;

    localparam int W  = 32;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int PL = 14;
    localparam int N  = H * V;

    typedef struct {
        int x;
        int y;
        int t;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    beat_t       sb[$];
    logic [31:0] got_re [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mandelbrot_scan_gen_if #(.WIDTH(W), .XW(XW), .YW(YW)) bus_a ();
    mandelbrot_scan_gen_if #(.WIDTH(W), .XW(XW), .YW(YW)) bus_b ();

    mandelbrot_scan_gen #(
        .WIDTH(W), .H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .PIPE_LATENCY(PL)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mandelbrot_scan_gen #(
        .WIDTH(W), .H_RES(1), .V_RES(1), .XW(XW), .YW(YW), .PIPE_LATENCY(1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Runs one frame on dut_a starting in an idle cycle and returns in the
    // cycle after done. en_mode: 0 always on, 1 pattern 1,0,0, 2 random.
    task automatic run_frame(input logic [31:0] re0, input logic [31:0] im0,
                             input logic [31:0] st, input int en_mode,
                             input bit poke_start);
        int          issued;
        int          iter;
        bit          scanning;
        bit          en_drv;
        bit          issue_now;
        bit          exp_rv;
        bit          exp_done;
        bit          frame_done;
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        logic [31:0] last_re;
        logic [31:0] last_im;
        beat_t       b;
        sb.delete();
        bus_a.re_origin = re0;
        bus_a.im_origin = im0;
        bus_a.step      = st;
        bus_a.start     = 1'b1;
        @(posedge clk); #1;
        bus_a.start     = 1'b0;
        bus_a.re_origin = $urandom;
        bus_a.im_origin = $urandom;
        bus_a.step      = $urandom;
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.c_valid !== 1'b0)
            $display("[TB] FAIL frame_start busy=%b c_valid=%b expected 1/0", bus_a.busy, bus_a.c_valid);
        else passes++;
        scanning   = 1'b1;
        issued     = 0;
        iter       = 0;
        frame_done = 1'b0;
        last_re    = re0;
        last_im    = im0;
        while (!frame_done && iter < 300) begin
            case (en_mode)
                0:       en_drv = 1'b1;
                1:       en_drv = (iter % 3 == 0);
                default: en_drv = 1'($urandom_range(0, 1));
            endcase
            bus_a.en    = en_drv;
            bus_a.start = poke_start ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(posedge clk); #1;
            iter++;
            issue_now = scanning && en_drv;
            checks++;
            if (bus_a.c_valid !== issue_now)
                $display("[TB] FAIL c_valid iter=%0d got=%b exp=%b", iter, bus_a.c_valid, issue_now);
            else passes++;
            if (issue_now) begin
                exp_re = re0 + st * 32'(issued % H);
                exp_im = im0 - st * 32'(issued / H);
                checks++;
                if (bus_a.c_real_out !== exp_re || bus_a.c_imag_out !== exp_im)
                    $display("[TB] FAIL c_value pix=%0d got=%h,%h exp=%h,%h", issued,
                             bus_a.c_real_out, bus_a.c_imag_out, exp_re, exp_im);
                else passes++;
                got_re[issued] = bus_a.c_real_out;
                b.x = issued % H;
                b.y = issued / H;
                b.t = cyc;
                b.last = (issued == N - 1);
                sb.push_back(b);
                last_re = exp_re;
                last_im = exp_im;
                issued++;
                if (issued == N) scanning = 1'b0;
            end else if (issued > 0) begin
                checks++;
                if (bus_a.c_real_out !== last_re || bus_a.c_imag_out !== last_im)
                    $display("[TB] FAIL c_hold got=%h,%h exp=%h,%h",
                             bus_a.c_real_out, bus_a.c_imag_out, last_re, last_im);
                else passes++;
            end
            exp_rv = (sb.size() > 0) && (cyc - sb[0].t == PL);
            checks++;
            if (bus_a.res_valid !== exp_rv)
                $display("[TB] FAIL res_valid cyc=%0d got=%b exp=%b", cyc, bus_a.res_valid, exp_rv);
            else passes++;
            exp_done = 1'b0;
            if (exp_rv) begin
                b = sb.pop_front();
                exp_done = b.last;
                checks++;
                if (bus_a.res_x !== XW'(b.x) || bus_a.res_y !== YW'(b.y))
                    $display("[TB] FAIL res_tag got=(%0d,%0d) exp=(%0d,%0d)",
                             bus_a.res_x, bus_a.res_y, b.x, b.y);
                else passes++;
            end
            checks++;
            if (bus_a.done !== exp_done)
                $display("[TB] FAIL done cyc=%0d got=%b exp=%b", cyc, bus_a.done, exp_done);
            else passes++;
            checks++;
            if (bus_a.busy !== 1'b1)
                $display("[TB] FAIL busy_in_frame got=%b exp=1", bus_a.busy);
            else passes++;
            if (exp_done) frame_done = 1'b1;
        end
        checks++;
        if (!frame_done)
            $display("[TB] FAIL frame_timeout finished=%b required=1", frame_done);
        else passes++;
        bus_a.en    = 1'b0;
        bus_a.start = poke_start;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.c_valid !== 1'b0)
            $display("[TB] FAIL after_done busy=%b done=%b c_valid=%b expected 0/0/0",
                     bus_a.busy, bus_a.done, bus_a.c_valid);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_a.start = 1'b0; bus_a.en = 1'b0;
        bus_a.re_origin = '0; bus_a.im_origin = '0; bus_a.step = '0;
        bus_b.start = 1'b0; bus_b.en = 1'b0;
        bus_b.re_origin = '0; bus_b.im_origin = '0; bus_b.step = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.c_valid, bus_a.res_valid, bus_a.busy, bus_a.done} !== 4'b0 ||
            bus_a.c_real_out !== 32'h0 || bus_a.c_imag_out !== 32'h0 ||
            bus_a.res_x !== '0 || bus_a.res_y !== '0)
            $display("[TB] FAIL reset_a flags=%b%b%b%b re=%h im=%h all expected 0",
                     bus_a.c_valid, bus_a.res_valid, bus_a.busy, bus_a.done,
                     bus_a.c_real_out, bus_a.c_imag_out);
        else passes++;
        checks++;
        if ({bus_b.c_valid, bus_b.res_valid, bus_b.busy, bus_b.done} !== 4'b0)
            $display("[TB] FAIL reset_b flags=%b%b%b%b expected 0000",
                     bus_b.c_valid, bus_b.res_valid, bus_b.busy, bus_b.done);
        else passes++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0020_0000, 0, 1'b0);
        checks++;
        if (got_re[0] !== 32'hFF80_0000 || got_re[1] !== 32'hFFA0_0000 ||
            got_re[2] !== 32'hFFC0_0000 || got_re[3] !== 32'hFFE0_0000)
            $display("[TB] FAIL row0_re got=%h %h %h %h exp=FF800000 FFA00000 FFC00000 FFE00000",
                     got_re[0], got_re[1], got_re[2], got_re[3]);
        else passes++;
    endtask

    task automatic test_bubbles();
        run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0020_0000, 1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0020_0000, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            run_frame($urandom, $urandom, 32'($urandom_range(1, 32'h0010_0000)), 2, f[0]);
        end
    endtask

    task automatic test_overflow();
        run_frame(32'h7FE0_0000, 32'h0000_0000, 32'h0020_0000, 0, 1'b0);
        checks++;
        if (got_re[1] !== 32'h8000_0000)
            $display("[TB] FAIL overflow_wrap got=%h exp=80000000", got_re[1]);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int beats;
        int iter;
        bus_a.re_origin = 32'hFF80_0000;
        bus_a.im_origin = 32'h0040_0000;
        bus_a.step      = 32'h0020_0000;
        bus_a.start     = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_a.en    = 1'b1;
        beats = 0;
        iter  = 0;
        while (beats < 6 && iter < 50) begin
            @(posedge clk); #1;
            iter++;
            if (bus_a.c_valid === 1'b1) beats++;
        end
        checks++;
        if (beats != 6)
            $display("[TB] FAIL mid_reset_beats got=%0d exp=6", beats);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus_a.c_valid, bus_a.res_valid, bus_a.busy, bus_a.done} !== 4'b0 ||
            bus_a.c_real_out !== 32'h0 || bus_a.c_imag_out !== 32'h0)
            $display("[TB] FAIL async_reset flags=%b%b%b%b re=%h im=%h all expected 0",
                     bus_a.c_valid, bus_a.res_valid, bus_a.busy, bus_a.done,
                     bus_a.c_real_out, bus_a.c_imag_out);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < PL + 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_a.res_valid !== 1'b0 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0)
                $display("[TB] FAIL post_reset cyc=%0d res_valid=%b done=%b busy=%b expected 0",
                         i, bus_a.res_valid, bus_a.done, bus_a.busy);
            else passes++;
        end
        bus_a.en = 1'b0;
        run_frame(32'hFF80_0000, 32'h0040_0000, 32'h0020_0000, 2, 1'b0);
    endtask

    task automatic test_single_pixel();
        logic [31:0] re;
        logic [31:0] im;
        for (int f = 0; f < 2; f++) begin
            re = $urandom;
            im = $urandom;
            bus_b.re_origin = re;
            bus_b.im_origin = im;
            bus_b.step      = 32'h0020_0000;
            bus_b.start     = 1'b1;
            bus_b.en        = 1'b1;
            @(posedge clk); #1;
            bus_b.start = 1'b0;
            checks++;
            if (bus_b.busy !== 1'b1 || bus_b.c_valid !== 1'b0)
                $display("[TB] FAIL single_start busy=%b c_valid=%b expected 1/0", bus_b.busy, bus_b.c_valid);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (bus_b.c_valid !== 1'b1 || bus_b.c_real_out !== re || bus_b.c_imag_out !== im ||
                bus_b.res_valid !== 1'b0 || bus_b.done !== 1'b0)
                $display("[TB] FAIL single_issue v=%b re=%h im=%h rv=%b d=%b exp 1 %h %h 0 0",
                         bus_b.c_valid, bus_b.c_real_out, bus_b.c_imag_out,
                         bus_b.res_valid, bus_b.done, re, im);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (bus_b.c_valid !== 1'b0 || bus_b.res_valid !== 1'b1 || bus_b.done !== 1'b1 ||
                bus_b.res_x !== '0 || bus_b.res_y !== '0)
                $display("[TB] FAIL single_result v=%b rv=%b d=%b x=%0d y=%0d exp 0 1 1 0 0",
                         bus_b.c_valid, bus_b.res_valid, bus_b.done, bus_b.res_x, bus_b.res_y);
            else passes++;
            bus_b.start = 1'b1;
            @(posedge clk); #1;
            bus_b.start = 1'b0;
            checks++;
            if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b0 || bus_b.res_valid !== 1'b0)
                $display("[TB] FAIL single_after busy=%b d=%b rv=%b expected 0 0 0",
                         bus_b.busy, bus_b.done, bus_b.res_valid);
            else passes++;
        end
        bus_b.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bubbles();
        test_start_ignored();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_single_pixel();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
